// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared constants and types for the VGA framebuffer path.
// Used by the timing controller and by the framebuffer fetch stage.
//   - Visible raster size (H_ACTIVE x V_ACTIVE) and framebuffer size (FB_W x FB_H).
//   - RAM address / colour widths and RGB444 field positions.
//   - addr_in_range(): true when a word address lies inside the framebuffer.
package vga_fb_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 350;
    localparam int unsigned FB_W     = 320;
    localparam int unsigned FB_H     = 175;
    localparam int unsigned FB_WORDS = FB_W * FB_H;
    localparam int unsigned AW       = 16;
    localparam int unsigned CW       = 12;

    // RGB444 field positions within a colour word.
    localparam int unsigned R_LSB = 0;
    localparam int unsigned R_MSB = 3;
    localparam int unsigned G_LSB = 4;
    localparam int unsigned G_MSB = 7;
    localparam int unsigned B_LSB = 8;
    localparam int unsigned B_MSB = 11;

    typedef logic [AW-1:0] fb_addr_t;
    typedef logic [CW-1:0] fb_color_t;

    function automatic logic addr_in_range(input fb_addr_t addr);
        return 32'(addr) < FB_WORDS;
    endfunction

endpackage

// File: rtl/vga_fb_fetch_if.sv
// vga_fb_fetch_if: CPU write port into the framebuffer fetch stage.
//   wr_valid  master -> slave  write request
//   wr_ready  slave  -> master write accepted when wr_valid & wr_ready
//   wr_addr   master -> slave  framebuffer word address (y*FB_W + x)
//   wr_data   master -> slave  pixel to write
interface vga_fb_fetch_if
    import vga_fb_pkg::*;
();

    logic      wr_valid;
    logic      wr_ready;
    fb_addr_t  wr_addr;
    fb_color_t wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/vga_fb_wrbuf.sv
// vga_fb_wrbuf: single-entry CPU write buffer with framebuffer range check.
//   clk, rst_n   clock, asynchronous active-low reset
//   wr           CPU write port (slave side); wr_ready = buffer empty
//   drain        the fetch stage is consuming the pending entry this cycle
//   pend         an in-range write is waiting for a free RAM slot
//   pend_addr    address of the pending write
//   pend_data    data of the pending write
//   oor_count    (only with VGA_FB_OOR_COUNT_EN) saturating count of accepted
//                writes whose address is outside the framebuffer
// Out-of-range writes are always accepted and dropped; they never set pend.
module vga_fb_wrbuf
    import vga_fb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    vga_fb_fetch_if.slave        wr,
    input  logic                 drain,
    output logic                 pend,
    output fb_addr_t             pend_addr,
    output fb_color_t            pend_data
`ifdef VGA_FB_OOR_COUNT_EN
    ,
    output logic [15:0]          oor_count
`endif
);

    logic      pend_q;
    fb_addr_t  addr_q;
    fb_color_t data_q;
    logic      accept;
    logic      in_range;

    assign wr.wr_ready = ~pend_q;
    assign accept      = wr.wr_valid & ~pend_q;
    assign in_range    = addr_in_range(wr.wr_addr);

    // Accept and drain are mutually exclusive: accept needs pend_q==0, drain needs pend_q==1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (accept && in_range) begin
            pend_q <= 1'b1;
            addr_q <= wr.wr_addr;
            data_q <= wr.wr_data;
        end else if (drain) begin
            pend_q <= 1'b0;
        end
    end

    assign pend      = pend_q;
    assign pend_addr = addr_q;
    assign pend_data = data_q;

`ifdef VGA_FB_OOR_COUNT_EN
    logic [15:0] oor_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oor_q <= '0;
        end else if (accept && !in_range && (oor_q != 16'hFFFF)) begin
            oor_q <= oor_q + 16'd1;
        end
    end

    assign oor_count = oor_q;
`endif

endmodule

// File: rtl/vga_fb_fetch.sv
// vga_fb_fetch: framebuffer fetch stage feeding the VGA timing controller.
// A 320x175 framebuffer is scanned out 2x-scaled to 640x350 from a single-port
// synchronous RAM; CPU writes are slotted into the cycles the scan-out leaves free.
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   px, py       raster position from the timing controller
//   color        pixel colour for the px/py presented one cycle earlier
//   wr           CPU write port (slave side of vga_fb_fetch_if)
//   ram_addr     RAM address (combinational)
//   ram_we       RAM write enable (combinational)
//   ram_wdata    RAM write data (combinational)
//   ram_rdata    RAM read data, valid one cycle after its address
//   oor_count    only when VGA_FB_OOR_COUNT_EN is defined: saturating count of
//                accepted out-of-range CPU writes
module vga_fb_fetch
    import vga_fb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           px,
    input  logic [9:0]           py,
    output fb_color_t            color,
    vga_fb_fetch_if.slave        wr,
    output fb_addr_t             ram_addr,
    output logic                 ram_we,
    output fb_color_t            ram_wdata,
    input  fb_color_t            ram_rdata
`ifdef VGA_FB_OOR_COUNT_EN
    ,
    output logic [15:0]          oor_count
`endif
);

    localparam logic [9:0] HActive = 10'(H_ACTIVE);
    localparam logic [9:0] VActive = 10'(V_ACTIVE);
    localparam logic [9:0] VLast   = 10'(V_ACTIVE - 1);
    localparam fb_addr_t   FbW     = AW'(FB_W);

    logic      active;
    logic      rd_slot;
    logic      drain;
    logic      pend;
    fb_addr_t  pend_addr;
    fb_color_t pend_data;

    fb_addr_t  line_base_q;
    fb_addr_t  line_base_d;
    logic      rd_q;
    logic      act_q;
    fb_color_t hold_q;

    // Out-of-range positions (px>=640 or py>=350, including values the controller
    // never produces) fall through as blanking.
    assign active  = (px < HActive) && (py < VActive);
    // Even visible pixels fetch a word; the following odd pixel reuses it.
    assign rd_slot = active && !px[0];
    assign drain   = pend && !rd_slot;

    vga_fb_wrbuf u_wrbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (wr),
        .drain     (drain),
        .pend      (pend),
        .pend_addr (pend_addr),
        .pend_data (pend_data)
`ifdef VGA_FB_OOR_COUNT_EN
        ,
        .oor_count (oor_count)
`endif
    );

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (rd_slot) begin
            ram_addr = line_base_q + {{(AW - 9){1'b0}}, px[9:1]};
        end else if (pend) begin
            ram_addr  = pend_addr;
            ram_we    = 1'b1;
            ram_wdata = pend_data;
        end
    end

    // Each framebuffer row covers two scan lines, so the base only advances
    // after the odd line of a pair and rewinds after the last visible line.
    always_comb begin
        line_base_d = line_base_q;
        if (px == HActive) begin
            if (py == VLast) begin
                line_base_d = '0;
            end else if (py[0]) begin
                line_base_d = line_base_q + FbW;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_base_q <= '0;
            rd_q        <= 1'b0;
            act_q       <= 1'b0;
            hold_q      <= '0;
        end else begin
            line_base_q <= line_base_d;
            rd_q        <= rd_slot;
            act_q       <= active;
            if (rd_q) begin
                hold_q <= ram_rdata;
            end
        end
    end

    assign color = act_q ? (rd_q ? ram_rdata : hold_q) : '0;

endmodule

// File: tb/tb_vga_fb_fetch.sv
// tb_vga_fb_fetch: self-checking bench for vga_fb_fetch with a synchronous RAM
// fixture (preloaded word n = n[11:0]) and a reference model kept at the level
// of the raster rules: address = (py/2)*320 + px/2, odd pixels show the last
// fetched word, accepted writes queue and land in the next free slot.
module tb_vga_fb_fetch;

    logic        clk;
    logic        rst_n;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [11:0] color;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [11:0] ram_wdata;
    logic [11:0] ram_rdata;
    logic        preload;
`ifdef VGA_FB_OOR_COUNT_EN
    logic [15:0] oor_count;
`endif

    vga_fb_fetch_if wr_if ();

    vga_fb_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .px        (px),
        .py        (py),
        .color     (color),
        .wr        (wr_if.slave),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
`ifdef VGA_FB_OOR_COUNT_EN
        ,
        .oor_count (oor_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM fixture: single port, synchronous read.
    logic [11:0] mem [0:65535];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 65536; i++) mem[16'(i)] <= 12'(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    // Reference model state.
    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int          x;
        int          y;
        int          addr;
        logic [11:0] col;
    } vec_t;

    logic [11:0] refmem [0:65535];
    wr_t         pq[$];
    logic [11:0] last_read;
    int          exp_oor;
    int          n_tests;
    int          n_fail;

    bit          rdy;
    logic [15:0] ga;
    bit          gw;
    logic [11:0] gc;
    vec_t        tbl [8];
    logic [11:0] line0 [0:799];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // One pixel clock: drive at negedge, check combinational outputs, advance the
    // model, then check the colour produced one cycle later.
    task automatic cycle(input int x, input int y, input bit v, input int a, input int d,
                         output bit rdy_o, output logic [15:0] addr_o, output bit we_o,
                         output logic [11:0] col_o);
        bit          act;
        bit          rd;
        bit          mready;
        bit          exp_we;
        int          row_addr;
        int          exp_a;
        int          exp_d;
        logic [11:0] exp_col;
        @(negedge clk);
        px = 10'(x);
        py = 10'(y);
        wr_if.wr_valid = v;
        wr_if.wr_addr  = 16'(a);
        wr_if.wr_data  = 12'(d);
        #1;
        act      = (x < 640) && (y < 350);
        rd       = act && (x % 2 == 0);
        row_addr = (y / 2) * 320 + x / 2;
        mready   = (pq.size() == 0);
        exp_d    = 0;
        if (rd) begin
            exp_we = 1'b0;
            exp_a  = row_addr;
        end else if (!mready) begin
            exp_we = 1'b1;
            exp_a  = pq[0].addr;
            exp_d  = pq[0].data;
        end else begin
            exp_we = 1'b0;
            exp_a  = 0;
        end
        rdy_o  = wr_if.wr_ready;
        addr_o = ram_addr;
        we_o   = ram_we;
        chk("ram_we", 32'(ram_we), 32'(exp_we));
        chk("ram_addr", 32'(ram_addr), 32'(exp_a));
        chk("wr_ready", 32'(wr_if.wr_ready), 32'(mready));
        if (exp_we) chk("ram_wdata", 32'(ram_wdata), 32'(exp_d));
        exp_col = 12'h000;
        if (rd) begin
            exp_col   = refmem[16'(row_addr)];
            last_read = refmem[16'(row_addr)];
        end else if (act) begin
            exp_col = last_read;
        end
        if (exp_we) begin
            refmem[16'(exp_a)] = 12'(exp_d);
            void'(pq.pop_front());
        end
        if (v && mready) begin
            if (a < 56000) pq.push_back('{addr: a, data: d});
            else if (exp_oor < 65535) exp_oor++;
        end
        @(posedge clk);
        #1;
        col_o = color;
        chk("color", 32'(color), 32'(exp_col));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int last_acc;
        int cyc;
        int bad;
        int b2b_addr [4];
        int b2b_data [4];

        tbl[0] = '{0, 2, 320, 12'h140};
        tbl[1] = '{1, 2, 0, 12'h140};
        tbl[2] = '{2, 2, 321, 12'h141};
        tbl[3] = '{3, 2, 0, 12'h141};
        tbl[4] = '{639, 2, 0, 12'h141};
        tbl[5] = '{800, 2, 0, 12'h000};
        tbl[6] = '{0, 400, 0, 12'h000};
        tbl[7] = '{1023, 1023, 0, 12'h000};
        b2b_addr = '{1000, 1001, 55999, 0};
        b2b_data = '{12'h111, 12'h222, 12'h333, 12'h444};

        n_tests   = 0;
        n_fail    = 0;
        exp_oor   = 0;
        last_read = 12'h000;
        for (int i = 0; i < 65536; i++) refmem[16'(i)] = 12'(i);

        // Reset state.
        rst_n          = 1'b0;
        preload        = 1'b1;
        px             = 10'd800;
        py             = 10'd0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_addr  = '0;
        wr_if.wr_data  = '0;
        #1;
        chk("reset_color", 32'(color), 32'h0);
        chk("reset_ram_we", 32'(ram_we), 32'h0);
        chk("reset_ram_addr", 32'(ram_addr), 32'h0);
        @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        rst_n   = 1'b1;
        #1;
        chk("reset_wr_ready", 32'(wr_if.wr_ready), 32'h1);

        // Sweep lines 0 and 1.
        for (int y = 0; y < 2; y++) begin
            bad = 0;
            for (int x = 0; x < 800; x++) begin
                cycle(x, y, 1'b0, 0, 0, rdy, ga, gw, gc);
                if (y == 0) line0[x] = gc;
                else if (gc !== line0[x]) bad++;
                if (y == 0 && x == 4) chk("px4_color", 32'(gc), 32'h002);
                if (y == 0 && x == 5) chk("px5_color", 32'(gc), 32'h002);
                if (y == 0 && x == 6) chk("px6_color", 32'(gc), 32'h003);
                if (y == 0 && x == 700) chk("px700_color", 32'(gc), 32'h000);
            end
            if (y == 1) chk("line1_repeats_line0", 32'(bad), 32'h0);
        end

        // Directed vectors around line 2 and out-of-range positions.
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].x, tbl[i].y, 1'b0, 0, 0, rdy, ga, gw, gc);
            chk("tbl_addr", 32'(ga), 32'(tbl[i].addr));
            chk("tbl_color", 32'(gc), 32'(tbl[i].col));
        end

        // Walk line ends to the last visible line, then wrap the frame.
        for (int y = 2; y <= 348; y++) cycle(640, y, 1'b0, 0, 0, rdy, ga, gw, gc);
        cycle(638, 349, 1'b0, 0, 0, rdy, ga, gw, gc);
        chk("last_word_addr", 32'(ga), 32'd55999);
        chk("last_word_color", 32'(gc), 32'hABF);
        cycle(640, 349, 1'b0, 0, 0, rdy, ga, gw, gc);
        cycle(2, 0, 1'b0, 0, 0, rdy, ga, gw, gc);
        chk("wrap_line_base", 32'(ga), 32'd1);

        // Write during active video at an even pixel.
        cycle(10, 0, 1'b1, 100, 12'hABC, rdy, ga, gw, gc);
        chk("act_wr_accept", 32'(rdy), 32'h1);
        cycle(11, 0, 1'b0, 0, 0, rdy, ga, gw, gc);
        chk("act_wr_we", 32'(gw), 32'h1);
        chk("act_wr_addr", 32'(ga), 32'd100);
        chk("act_wr_busy", 32'(rdy), 32'h0);
        cycle(12, 0, 1'b0, 0, 0, rdy, ga, gw, gc);
        chk("act_wr_ready_again", 32'(rdy), 32'h1);
        chk("act_wr_we_off", 32'(gw), 32'h0);

        // Back-to-back writes in blanking, valid held until accepted.
        k        = 0;
        last_acc = -1;
        cyc      = 0;
        while (k < 4 && cyc < 40) begin
            cycle(cyc, 360, 1'b1, b2b_addr[k], b2b_data[k], rdy, ga, gw, gc);
            if (rdy) begin
                if (k > 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'd2);
                last_acc = cyc;
                k++;
            end
            cyc++;
        end
        chk("b2b_all_accepted", 32'(k), 32'd4);
        repeat (2) cycle(100, 360, 1'b0, 0, 0, rdy, ga, gw, gc);

        // Out-of-range write is accepted and dropped.
`ifdef VGA_FB_OOR_COUNT_EN
        chk("oor_count_before", 32'(oor_count), 32'd0);
`endif
        cycle(100, 360, 1'b1, 56000, 12'h123, rdy, ga, gw, gc);
        chk("oor_accept", 32'(rdy), 32'h1);
        for (int i = 0; i < 3; i++) begin
            cycle(101 + i, 360, 1'b0, 0, 0, rdy, ga, gw, gc);
            chk("oor_no_we", 32'(gw), 32'h0);
        end
`ifdef VGA_FB_OOR_COUNT_EN
        chk("oor_count_after", 32'(oor_count), 32'd1);
`endif

        // Randomised raster positions and writes against the model.
        for (int i = 0; i < 3000; i++) begin
            int x;
            int y;
            bit v;
            int a;
            int d;
            x = int'($urandom_range(0, 799));
            if (x == 640) x = 641;
            case ($urandom_range(0, 3))
                0:       y = 0;
                1:       y = 1;
                default: y = int'($urandom_range(350, 524));
            endcase
            v = ($urandom_range(0, 2) == 0);
            a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(56000, 65535))
                                            : int'($urandom_range(0, 55999));
            d = int'($urandom_range(0, 4095));
            cycle(x, y, v, a, d, rdy, ga, gw, gc);
        end
        repeat (3) cycle(700, 360, 1'b0, 0, 0, rdy, ga, gw, gc);
`ifdef VGA_FB_OOR_COUNT_EN
        chk("oor_count_random", 32'(oor_count), 32'(exp_oor));
`endif

        // Asynchronous reset while a write is pending on an odd pixel.
        cycle(20, 0, 1'b1, 200, 12'h5A5, rdy, ga, gw, gc);
        chk("rst_pre_accept", 32'(rdy), 32'h1);
        @(negedge clk);
        px             = 10'd21;
        py             = 10'd0;
        wr_if.wr_valid = 1'b0;
        #1;
        chk("rst_pre_we", 32'(ram_we), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_we", 32'(ram_we), 32'h0);
        chk("rst_async_color", 32'(color), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pq.delete();
        last_read = 12'h000;
        exp_oor   = 0;
        chk("rst_ram_unchanged", 32'(mem[16'd200]), 32'(refmem[16'd200]));
        cycle(800, 0, 1'b0, 0, 0, rdy, ga, gw, gc);
        chk("rst_release_ready", 32'(rdy), 32'h1);
        cycle(1, 0, 1'b0, 0, 0, rdy, ga, gw, gc);
        chk("rst_hold_cleared", 32'(gc), 32'h0);

        // Final RAM contents against the model.
        bad = 0;
        for (int i = 0; i < 65536; i++) if (mem[16'(i)] !== refmem[16'(i)]) bad++;
        chk("ram_contents", 32'(bad), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
